// File: rtl/scan_mux.sv
// N-channel, W-bit registered multiplexer. Channels are chosen by an external select
// or by a round-robin scanner that stays DWELL enabled cycles on each channel.
module scan_mux #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
);

  localparam int NP  = 1 << SW;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]    N_EXT     = (SW + 1)'(N);
  localparam logic [SW-1:0]  LAST_CH   = SW'(N - 1);
  localparam logic [DCW-1:0] LAST_DWELL = DCW'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t         state_reg, state_next;
  logic [SW-1:0]  scan_ch_reg, scan_ch_next;
  logic [DCW-1:0] dwell_reg, dwell_next;
  logic [W-1:0]   dout_reg, dout_next;
  logic [SW-1:0]  ch_reg, ch_next;
  logic           valid_reg, valid_next;
  logic           wrap_reg, wrap_next;

  logic [W-1:0]   chan [NP];
  logic           sel_ok;
  logic           last_ch;
  logic           last_dwell;

  // Pad the channel table to a power of two so unused select codes read as zero.
  for (genvar gi = 0; gi < NP; gi++) begin : g_chan
    if (gi < N) begin : g_used
      assign chan[gi] = din[gi*W +: W];
    end else begin : g_pad
      assign chan[gi] = '0;
    end
  end

  assign sel_ok     = {1'b0, sel} < N_EXT;
  assign last_ch    = (scan_ch_reg == LAST_CH);
  assign last_dwell = (dwell_reg == LAST_DWELL);

  always_comb begin
    state_next   = mode ? SCAN : MANUAL;
    scan_ch_next = scan_ch_reg;
    dwell_next   = dwell_reg;
    dout_next    = dout_reg;
    ch_next      = ch_reg;
    valid_next   = 1'b0;
    wrap_next    = 1'b0;

    if (!mode) begin
      // Leaving SCAN rewinds the scanner; in MANUAL it already sits at zero.
      if (state_reg == SCAN) begin
        scan_ch_next = '0;
        dwell_next   = '0;
      end
      if (en) begin
        dout_next  = chan[sel];
        ch_next    = sel;
        valid_next = sel_ok;
      end
    end else if (en) begin
      dout_next  = chan[scan_ch_reg];
      ch_next    = scan_ch_reg;
      valid_next = 1'b1;
      wrap_next  = last_ch && last_dwell;
      if (last_dwell) begin
        dwell_next   = '0;
        scan_ch_next = last_ch ? '0 : scan_ch_reg + SW'(1);
      end else begin
        dwell_next = dwell_reg + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MANUAL;
      scan_ch_reg <= '0;
      dwell_reg   <= '0;
      dout_reg    <= '0;
      ch_reg      <= '0;
      valid_reg   <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      scan_ch_reg <= scan_ch_next;
      dwell_reg   <= dwell_next;
      dout_reg    <= dout_next;
      ch_reg      <= ch_next;
      valid_reg   <= valid_next;
      wrap_reg    <= wrap_next;
    end
  end

  assign dout  = dout_reg;
  assign ch    = ch_reg;
  assign valid = valid_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: the driver pushes expected samples from an arithmetic
// model of the scan sequence; a monitor pops and compares one entry per clock.
module tb_scan_mux;

  localparam int N     = 5;
  localparam int W     = 4;
  localparam int DWELL = 2;
  localparam int SW    = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] c;
    logic          v;
    logic          w;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] din = '0;
  logic [SW-1:0]  sel = '0;
  logic           mode = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   dout;
  logic [SW-1:0]  ch;
  logic           valid;
  logic           wrap;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Model: pos counts enabled scan samples since the scanner last rewound.
  int            pos = 0;
  logic [W-1:0]  m_dout = '0;
  logic [SW-1:0] m_ch = '0;

  scan_mux #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en),
    .dout(dout), .ch(ch), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic m, input logic e, input int s, input logic [N*W-1:0] d);
    exp_t x;
    int   c;
    mode = m; en = e; sel = SW'(s); din = d;
    x.v = 1'b0;
    x.w = 1'b0;
    if (!m) pos = 0;
    if (e) begin
      if (!m) begin
        m_ch   = SW'(s);
        m_dout = (s < N) ? d[s*W +: W] : '0;
        x.v    = (s < N);
      end else begin
        c      = (pos / DWELL) % N;
        m_ch   = SW'(c);
        m_dout = d[c*W +: W];
        x.v    = 1'b1;
        x.w    = (pos % (N*DWELL)) == (N*DWELL - 1);
        pos++;
      end
    end
    x.d = m_dout;
    x.c = m_ch;
    q.push_back(x);
  endtask

  task automatic model_reset();
    q.delete();
    pos = 0; m_dout = '0; m_ch = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && mon_en) begin
      exp_t x;
      #1;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sample: output cycle with empty scoreboard at %0t", $time);
      end else begin
        x = q.pop_front();
        if (dout !== x.d || ch !== x.c || valid !== x.v || wrap !== x.w) begin
          errors++;
          $display("FAIL sample @%0t: got dout=%0d ch=%0d valid=%b wrap=%b, expected dout=%0d ch=%0d valid=%b wrap=%b",
                   $time, dout, ch, valid, wrap, x.d, x.c, x.v, x.w);
        end else begin
          $display("sample @%0t: dout=%0d ch=%0d valid=%b wrap=%b", $time, dout, ch, valid, wrap);
        end
      end
    end
  end

  function automatic logic [N*W-1:0] ramp_din();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 3);
    return d;
  endfunction

  initial begin
    logic m_r;
    model_reset();
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(valid), 0);

    // Manual sweep including out-of-range selects 5..7
    @(negedge clk); rst_n = 1'b1; drive(0, 1, 0, ramp_din());
    for (int s = 1; s < 8; s++) begin @(negedge clk); drive(0, 1, s, ramp_din()); end

    // Continuous scan: two full periods
    for (int i = 0; i < 2*N*DWELL; i++) begin @(negedge clk); drive(1, 1, 0, N*W'($urandom)); end

    // Enable gaps
    for (int i = 0; i < 2*N*DWELL; i++) begin @(negedge clk); drive(1, i % 2 == 0, 0, N*W'($urandom)); end

    // Mode switch mid-dwell
    apply_reset();
    rst_n = 1'b1; drive(1, 1, 0, ramp_din());
    @(negedge clk); drive(1, 1, 0, ramp_din());
    @(negedge clk); drive(0, 1, 2, ramp_din());
    for (int i = 0; i < 4; i++) begin @(negedge clk); drive(1, 1, 0, ramp_din()); end

    // Asynchronous reset mid-scan, no clock edge involved
    for (int i = 0; i < 3; i++) begin @(negedge clk); drive(1, 1, 0, ramp_din()); end
    @(negedge clk); drive(1, 1, 0, ramp_din());
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_dout", int'(dout), 0);
    chk("async_ch", int'(ch), 0);
    chk("async_valid", int'(valid), 0);
    chk("async_wrap", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1; drive(1, 1, 0, ramp_din());

    // Random traffic with sticky mode
    m_r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) m_r = ~m_r;
      drive(m_r, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), N*W'($urandom));
    end

    @(posedge clk); #3;
    mon_en = 1'b0;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
